// File: rtl/seq_alu.sv
// Multi-cycle ALU: 1-cycle logic/add/shift ops, iterative shift-add MUL and restoring DIV.
// Optional divider built only when SEQ_ALU_DIV_EN is defined; otherwise opcode 0x03 is illegal.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [4:0]           op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err,
  output logic [1:0]           state_dbg
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [4:0] OP_ADD   = 5'h00;
  localparam logic [4:0] OP_SUB   = 5'h01;
  localparam logic [4:0] OP_MUL   = 5'h02;
  localparam logic [4:0] OP_DIV   = 5'h03;
  localparam logic [4:0] OP_AND   = 5'h04;
  localparam logic [4:0] OP_OR    = 5'h05;
  localparam logic [4:0] OP_XOR   = 5'h06;
  localparam logic [4:0] OP_NOR   = 5'h07;
  localparam logic [4:0] OP_SLL   = 5'h08;
  localparam logic [4:0] OP_SRL   = 5'h09;
  localparam logic [4:0] OP_SRA   = 5'h0A;
  localparam logic [4:0] OP_SLT   = 5'h0B;
  localparam logic [4:0] OP_SLTU  = 5'h0C;
  localparam logic [4:0] OP_PASSA = 5'h0D;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid/result/err stay frozen until that edge, and in_ready is high only in IDLE.
  state_e               state_q, state_d;
  logic [SHW-1:0]       cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opa_q, opa_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 err_q, err_d;
  logic                 out_valid_q, out_valid_d;
  logic                 in_ready_q, in_ready_d;
`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic                 is_mul_q, is_mul_d;
`endif

  function automatic logic [2*WIDTH-1:0] zext(input logic [WIDTH-1:0] v);
    return {{WIDTH{1'b0}}, v};
  endfunction

  logic [WIDTH:0]       add_sum;
  logic [WIDTH:0]       sub_diff;
  logic [SHW-1:0]       shamt;
  logic [WIDTH-1:0]     sra_val;
  logic                 slt_s;
  logic                 slt_u;
  logic [2*WIDTH-1:0]   fast_res;
  logic                 fast_err;
  logic                 is_iter;

  assign add_sum  = {1'b0, a} + {1'b0, b};
  assign sub_diff = {1'b0, a} - {1'b0, b};
  assign shamt    = b[SHW-1:0];
  assign sra_val  = WIDTH'($signed(a) >>> shamt);
  assign slt_s    = $signed(a) < $signed(b);
  assign slt_u    = a < b;

  always_comb begin
    fast_res = '0;
    fast_err = 1'b0;
    is_iter  = 1'b0;
    case (op)
      OP_ADD:   fast_res = {{(WIDTH-1){1'b0}}, add_sum};
      OP_SUB:   fast_res = {{(WIDTH-1){1'b0}}, sub_diff};
      OP_MUL:   is_iter  = 1'b1;
`ifdef SEQ_ALU_DIV_EN
      OP_DIV: begin
        // Divide-by-zero short-circuits: quotient all ones, remainder = dividend.
        if (b == '0) begin
          fast_res = {a, {WIDTH{1'b1}}};
          fast_err = 1'b1;
        end else begin
          is_iter = 1'b1;
        end
      end
`endif
      OP_AND:   fast_res = zext(a & b);
      OP_OR:    fast_res = zext(a | b);
      OP_XOR:   fast_res = zext(a ^ b);
      OP_NOR:   fast_res = zext(~(a | b));
      OP_SLL:   fast_res = zext(a << shamt);
      OP_SRL:   fast_res = zext(a >> shamt);
      OP_SRA:   fast_res = zext(sra_val);
      OP_SLT:   fast_res = {{(2*WIDTH-1){1'b0}}, slt_s};
      OP_SLTU:  fast_res = {{(2*WIDTH-1){1'b0}}, slt_u};
      OP_PASSA: fast_res = zext(a);
      default:  fast_err = 1'b1;
    endcase
  end

  // Shift-add multiply: acc = {partial product hi, multiplier lo}, shifted right each step.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH-1:0]   iter_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
  // Restoring divide: acc = {remainder hi, dividend/quotient lo}, shifted left each step.
  logic [WIDTH:0]       div_rem_sh;
  logic [WIDTH:0]       div_diff;
  logic [WIDTH-1:0]     div_lo_sh;
  logic [2*WIDTH-1:0]   div_next;

  assign div_rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff   = div_rem_sh - {1'b0, opb_q};
  assign div_lo_sh  = {acc_q[WIDTH-2:0], 1'b0};
  assign div_next   = div_diff[WIDTH] ? {div_rem_sh[WIDTH-1:0], div_lo_sh}
                                      : {div_diff[WIDTH-1:0], div_lo_sh[WIDTH-1:1], 1'b1};
  assign iter_next  = is_mul_q ? mul_next : div_next;
`else
  assign iter_next  = mul_next;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opa_d       = opa_q;
    result_d    = result_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
`ifdef SEQ_ALU_DIV_EN
    opb_d       = opb_q;
    is_mul_d    = is_mul_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          in_ready_d = 1'b0;
          if (is_iter) begin
            state_d = S_BUSY;
            cnt_d   = '0;
            opa_d   = a;
            acc_d   = (op == OP_MUL) ? zext(b) : zext(a);
`ifdef SEQ_ALU_DIV_EN
            opb_d    = b;
            is_mul_d = (op == OP_MUL);
`endif
          end else begin
            state_d     = S_DONE;
            result_d    = fast_res;
            err_d       = fast_err;
            out_valid_d = 1'b1;
          end
        end
      end
      S_BUSY: begin
        acc_d = iter_next;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == SHW'(WIDTH-1)) begin
          state_d     = S_DONE;
          result_d    = iter_next;
          err_d       = 1'b0;
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opa_q       <= '0;
      result_q    <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef SEQ_ALU_DIV_EN
      opb_q       <= '0;
      is_mul_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opa_q       <= opa_d;
      result_q    <= result_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
`ifdef SEQ_ALU_DIV_EN
      opb_q       <= opb_d;
      is_mul_q    <= is_mul_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu (WIDTH=32); DIV expectations follow SEQ_ALU_DIV_EN.
module tb_seq_alu;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [4:0]    op;
  logic          out_valid;
  logic          out_ready;
  logic [2*W-1:0] result;
  logic          err;
  logic [1:0]    state_dbg;

  int vectors = 0;
  int miscompares = 0;
  logic [2*W-1:0] exp_q[$];

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .err       (err),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one op, scramble inputs afterwards, wait (bounded) for out_valid, check all outputs.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [4:0] top, input logic [2*W-1:0] eres, input logic eerr,
                        input int elat);
    int lat;
    logic rdy_seen;
    logic [2*W-1:0] exp_res;
    @(negedge clk);
    check({tag, " in_ready idle"}, 64'(in_ready), 64'd1);
    a = ta; b = tb; op = top; in_valid = 1'b1;
    exp_q.push_back(eres);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 5'($urandom_range(0, 31));
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    exp_res = exp_q.pop_front();
    check({tag, " latency"}, 64'(lat), 64'(elat));
    check({tag, " result"}, result, exp_res);
    check({tag, " err"}, 64'(err), 64'(eerr));
    check({tag, " in_ready busy"}, 64'(rdy_seen | in_ready), 64'd0);
    if (out_ready) begin
      @(negedge clk);
      check({tag, " in_ready after"}, 64'({in_ready, out_valid}), 64'b10);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset result", result, 64'd0);
    check("reset err", 64'(err), 64'd0);

    // Sweep with a=0x0A, b=0x02
    run_op("add",   32'h0A, 32'h02, 5'h00, 64'h0C, 1'b0, 1);
    run_op("sub",   32'h0A, 32'h02, 5'h01, 64'h08, 1'b0, 1);
    run_op("mul",   32'h0A, 32'h02, 5'h02, 64'h14, 1'b0, 33);
`ifdef SEQ_ALU_DIV_EN
    run_op("div",   32'h0A, 32'h02, 5'h03, 64'h0000_0000_0000_0005, 1'b0, 33);
`else
    run_op("div",   32'h0A, 32'h02, 5'h03, 64'h0, 1'b1, 1);
`endif
    run_op("and",   32'h0A, 32'h02, 5'h04, 64'h02, 1'b0, 1);
    run_op("or",    32'h0A, 32'h02, 5'h05, 64'h0A, 1'b0, 1);
    run_op("xor",   32'h0A, 32'h02, 5'h06, 64'h08, 1'b0, 1);
    run_op("nor",   32'h0A, 32'h02, 5'h07, 64'h0000_0000_FFFF_FFF5, 1'b0, 1);
    run_op("sll",   32'h0A, 32'h02, 5'h08, 64'h28, 1'b0, 1);
    run_op("srl",   32'h0A, 32'h02, 5'h09, 64'h02, 1'b0, 1);
    run_op("sra",   32'h0A, 32'h02, 5'h0A, 64'h02, 1'b0, 1);
    run_op("slt",   32'h0A, 32'h02, 5'h0B, 64'h00, 1'b0, 1);
    run_op("sltu",  32'h0A, 32'h02, 5'h0C, 64'h00, 1'b0, 1);
    run_op("passa", 32'h0A, 32'h02, 5'h0D, 64'h0A, 1'b0, 1);

    // Boundary and sign cases
    run_op("add carry", 32'hFFFF_FFFF, 32'h1, 5'h00, 64'h1_0000_0000, 1'b0, 1);
    run_op("slt neg",   32'hFFFF_FFFF, 32'h1, 5'h0B, 64'h1, 1'b0, 1);
    run_op("sltu neg",  32'hFFFF_FFFF, 32'h1, 5'h0C, 64'h0, 1'b0, 1);
    run_op("sra neg",   32'h8000_0000, 32'h24, 5'h0A, 64'h0000_0000_F800_0000, 1'b0, 1);
    run_op("mul F6",    32'hF6, 32'h0A, 5'h02, 64'h99C, 1'b0, 33);
    run_op("mul max",   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h02, 64'hFFFF_FFFE_0000_0001, 1'b0, 33);
`ifdef SEQ_ALU_DIV_EN
    run_op("div F6",    32'hF6, 32'h0A, 5'h03, {32'h6, 32'h18}, 1'b0, 33);
    run_op("div zero",  32'hF6, 32'h00, 5'h03, {32'hF6, 32'hFFFF_FFFF}, 1'b1, 1);
`else
    run_op("div off",   32'hF6, 32'h0A, 5'h03, 64'h0, 1'b1, 1);
    run_op("div off0",  32'hF6, 32'h00, 5'h03, 64'h0, 1'b1, 1);
`endif
    run_op("illegal 1F", 32'h5, 32'h6, 5'h1F, 64'h0, 1'b1, 1);
    run_op("illegal 0E", 32'h5, 32'h6, 5'h0E, 64'h0, 1'b1, 1);

    // Backpressure: result held for 5 cycles with out_ready low
    out_ready = 1'b0;
    run_op("sub bp", 32'h1, 32'h2, 5'h01, 64'h1_FFFF_FFFF, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp hold", {result[62:0], out_valid}, {63'h1_FFFF_FFFF, 1'b1});
      check("bp in_ready", 64'({in_ready, err}), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp release", 64'({in_ready, out_valid}), 64'b10);

    // Reset in the middle of a MUL
    a = 32'hF6; b = 32'h0A; op = 5'h02; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid busy", 64'({in_ready, out_valid}), 64'b00);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort flags", 64'({in_ready, out_valid}), 64'b10);
    check("abort result", result, 64'd0);
    run_op("add after rst", 32'h0A, 32'h02, 5'h00, 64'h0C, 1'b0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
